// File: rtl/sistema_de_lectura.sv
// 4x4 matrix keypad reader: rotating one-hot column strobe, two-flop row
// synchronizer, press/release debouncing and a single latched key event that
// the consumer collects with a read-acknowledge handshake.
module sistema_de_lectura #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_PULSES = 3,
    parameter int SCAN_CYCLES     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [WIDTH-1:0]    col,
    input  logic [WIDTH-1:0]    fil,
    output logic [WIDTH-1:0]    pressed_col_out,
    output logic [WIDTH-1:0]    pressed_row_out,
    output logic                pressed_valid,
    input  logic                ack_read,
    output logic signed [31:0]  numero,
    output logic                rst,
    guardar
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_PULSES + 1);
    localparam logic [WIDTH-1:0] COL_FIRST = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  fil_m;
    logic [WIDTH-1:0]  fil_s;
    logic [WIDTH-1:0]  col_d1;
    logic [WIDTH-1:0]  col_d;
    logic [CW-1:0]     scan_cnt;
    logic [DW-1:0]     deb_cnt;
    logic [WIDTH-1:0]  sample;
    logic [WIDTH-1:0]  cap_col;

    // True when exactly one row line is active; multi-row presses are ambiguous.
    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Keypad legend: digits keep their value, A..D = 10..13, '*' = 14, '#' = 15.
    function automatic logic signed [31:0] key_code(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] c);
        logic [1:0] ri;
        logic [1:0] ci;
        logic signed [31:0] code;
        ri = 2'd0;
        ci = 2'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r[i]) ri = 2'(i);
            if (c[i]) ci = 2'(i);
        end
        case ({ri, ci})
            4'h0: code = 32'sd1;
            4'h1: code = 32'sd2;
            4'h2: code = 32'sd3;
            4'h3: code = 32'sd10;
            4'h4: code = 32'sd4;
            4'h5: code = 32'sd5;
            4'h6: code = 32'sd6;
            4'h7: code = 32'sd11;
            4'h8: code = 32'sd7;
            4'h9: code = 32'sd8;
            4'hA: code = 32'sd9;
            4'hB: code = 32'sd12;
            4'hC: code = 32'sd14;
            4'hD: code = 32'sd0;
            4'hE: code = 32'sd15;
            default: code = 32'sd13;
        endcase
        return code;
    endfunction

    // Two-flop row synchronizer with a matching column delay line, so every
    // synchronized row sample is paired with the strobe that produced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fil_m  <= '0;
            fil_s  <= '0;
            col_d1 <= '0;
            col_d  <= '0;
        end else begin
            fil_m  <= fil;
            fil_s  <= fil_m;
            col_d1 <= col;
            col_d  <= col_d1;
        end
    end

    // Column strobe rotation; frozen (counter included) while any row is seen
    // or the press FSM is busy, so the pressed column stays driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= COL_FIRST;
            scan_cnt <= '0;
        end else if (state == SCAN && fil_s == '0) begin
            if (scan_cnt == CW'(SCAN_CYCLES - 1)) begin
                col      <= {col[WIDTH-2:0], col[WIDTH-1]};
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Press/release debouncing FSM plus the event latch and its acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SCAN;
            deb_cnt         <= '0;
            sample          <= '0;
            cap_col         <= '0;
            pressed_col_out <= '0;
            pressed_row_out <= '0;
            pressed_valid   <= 1'b0;
            numero          <= '0;
        end else begin
            // A latch only happens with pressed_valid low, so it never
            // collides with this clear.
            if (ack_read && pressed_valid) begin
                pressed_valid <= 1'b0;
            end

            case (state)
                SCAN: begin
                    if (fil_s != '0) begin
                        sample  <= fil_s;
                        cap_col <= col_d;
                        deb_cnt <= DW'(1);
                        if (DEBOUNCE_PULSES == 1) begin
                            if (is_onehot(fil_s) && !pressed_valid) begin
                                pressed_col_out <= col_d;
                                pressed_row_out <= fil_s;
                                numero          <= key_code(fil_s, col_d);
                                pressed_valid   <= 1'b1;
                            end
                            state <= HELD;
                        end else begin
                            state <= DEBOUNCE;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (fil_s == sample) begin
                        if (deb_cnt == DW'(DEBOUNCE_PULSES - 1)) begin
                            if (is_onehot(sample) && !pressed_valid) begin
                                pressed_col_out <= cap_col;
                                pressed_row_out <= sample;
                                numero          <= key_code(sample, cap_col);
                                pressed_valid   <= 1'b1;
                            end
                            state <= HELD;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else if (fil_s != '0) begin
                        // Rows changed but still pressed: restart on new pattern.
                        sample  <= fil_s;
                        cap_col <= col_d;
                        deb_cnt <= DW'(1);
                    end else begin
                        state <= SCAN;
                    end
                end

                HELD: begin
                    if (fil_s == '0) begin
                        deb_cnt <= DW'(1);
                        state   <= (DEBOUNCE_PULSES == 1) ? SCAN : RELEASE;
                    end
                end

                RELEASE: begin
                    if (fil_s != '0) begin
                        state <= HELD;
                    end else if (deb_cnt == DW'(DEBOUNCE_PULSES - 1)) begin
                        state <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

    // Command flags derived from the pending event.
    assign rst     = pressed_valid && (numero == 32'sd14);
    assign guardar = pressed_valid && (numero == 32'sd15);

endmodule

// File: tb/tb_sistema_de_lectura.sv
// Directed bench for the keypad reader: scan rotation, latency, decoding,
// command flags, handshake, bounce rejection, multi-row and mid-press reset.
module tb_sistema_de_lectura;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         col;
    logic [3:0]         fil;
    logic [3:0]         pcol;
    logic [3:0]         prow;
    logic               pv;
    logic               ack_read;
    logic signed [31:0] numero;
    logic               rst;
    logic               guardar;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sistema_de_lectura #(
        .WIDTH(4),
        .DEBOUNCE_PULSES(3),
        .SCAN_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col(col),
        .fil(fil),
        .pressed_col_out(pcol),
        .pressed_row_out(prow),
        .pressed_valid(pv),
        .ack_read(ack_read),
        .numero(numero),
        .rst(rst),
        .guardar(guardar)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Returns just after the edge on which col switches to target.
    task automatic wait_col(input logic [3:0] target);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = col;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (col == target && prev != target) found = 1'b1;
            prev = col;
        end
        if (!found) check("wait_col_timeout", 32'd0, 32'd1);
    endtask

    task automatic press_check(input logic [3:0] c, input logic [3:0] rows, input int hold,
                               input int exp_num, input logic exp_rst, input logic exp_g);
        wait_col(c);
        @(negedge clk);
        fil = rows;
        repeat (5) @(posedge clk);
        #1;
        check("press_valid", 32'(pv), 32'd1);
        check("press_pcol", 32'(pcol), 32'(c));
        check("press_prow", 32'(prow), 32'(rows));
        check("press_numero", numero, exp_num);
        check("press_rst", 32'(rst), 32'(exp_rst));
        check("press_guardar", 32'(guardar), 32'(exp_g));
        repeat (hold) @(negedge clk);
        fil = 4'b0000;
        repeat (12) @(negedge clk);
        ack_read = 1'b1;
        @(posedge clk);
        #1;
        check("ack_valid", 32'(pv), 32'd0);
        check("ack_rst", 32'(rst), 32'd0);
        check("ack_guardar", 32'(guardar), 32'd0);
        check("ack_numero_kept", numero, exp_num);
        @(negedge clk);
        ack_read = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        fil      = 4'b0000;
        ack_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", 32'(col), 32'h1);
        check("rst_valid", 32'(pv), 32'd0);
        check("rst_numero", numero, 32'd0);
        check("rst_pcol", 32'(pcol), 32'd0);
        check("rst_prow", 32'(prow), 32'd0);
        check("rst_rst", 32'(rst), 32'd0);
        check("rst_guardar", 32'(guardar), 32'd0);

        // Idle scan: 8 cycles per column.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("scan_hold0", 32'(col), 32'h1);
        @(posedge clk);
        #1;
        check("scan_col1", 32'(col), 32'h2);
        repeat (8) @(posedge clk);
        #1;
        check("scan_col2", 32'(col), 32'h4);
        repeat (8) @(posedge clk);
        #1;
        check("scan_col3", 32'(col), 32'h8);
        repeat (8) @(posedge clk);
        #1;
        check("scan_wrap", 32'(col), 32'h1);
        check("scan_valid", 32'(pv), 32'd0);

        // Key '7': latency, decoding, freeze, second press while pending.
        wait_col(4'b0001);
        @(negedge clk);
        fil = 4'b0100;
        repeat (4) @(posedge clk);
        #1;
        check("k7_early", 32'(pv), 32'd0);
        @(posedge clk);
        #1;
        check("k7_valid", 32'(pv), 32'd1);
        check("k7_pcol", 32'(pcol), 32'h1);
        check("k7_prow", 32'(prow), 32'h4);
        check("k7_numero", numero, 32'd7);
        check("k7_rst", 32'(rst), 32'd0);
        check("k7_guardar", 32'(guardar), 32'd0);
        repeat (95) @(posedge clk);
        #1;
        check("k7_col_frozen", 32'(col), 32'h1);
        @(negedge clk);
        fil = 4'b0000;
        repeat (20) @(negedge clk);
        fil = 4'b0010;
        repeat (20) @(negedge clk);
        fil = 4'b0000;
        check("pend_valid", 32'(pv), 32'd1);
        check("pend_numero", numero, 32'd7);
        check("pend_prow", 32'(prow), 32'h4);
        check("pend_pcol", 32'(pcol), 32'h1);
        repeat (30) @(negedge clk);
        ack_read = 1'b1;
        @(posedge clk);
        #1;
        check("k7_ack", 32'(pv), 32'd0);
        check("k7_pcol_kept", 32'(pcol), 32'h1);
        check("k7_numero_kept", numero, 32'd7);
        @(negedge clk);
        ack_read = 1'b1;
        @(negedge clk);
        ack_read = 1'b0;
        check("idle_ack_ignored", 32'(pv), 32'd0);

        // Decoding and command flags.
        press_check(4'b0001, 4'b0001, 40, 1, 1'b0, 1'b0);
        press_check(4'b0001, 4'b1000, 20, 14, 1'b1, 1'b0);
        press_check(4'b0100, 4'b1000, 20, 15, 1'b0, 1'b1);

        // Bounce: 10 toggling cycles, then stable.
        wait_col(4'b0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            fil = (i % 2 == 0) ? 4'b0100 : 4'b0000;
        end
        @(negedge clk);
        fil = 4'b0100;
        repeat (4) @(posedge clk);
        #1;
        check("bounce_early", 32'(pv), 32'd0);
        @(posedge clk);
        #1;
        check("bounce_valid", 32'(pv), 32'd1);
        check("bounce_numero", numero, 32'd7);
        check("bounce_pcol", 32'(pcol), 32'h1);
        repeat (20) @(negedge clk);
        ack_read = 1'b1;
        @(negedge clk);
        ack_read = 1'b0;
        check("bounce_ack", 32'(pv), 32'd0);
        fil = 4'b0000;
        @(negedge clk);
        fil = 4'b0100;
        repeat (20) @(negedge clk);
        check("no_second_event", 32'(pv), 32'd0);
        fil = 4'b0000;
        repeat (20) @(negedge clk);

        // Two rows at once: ambiguous, never latched.
        wait_col(4'b0001);
        @(negedge clk);
        fil = 4'b0110;
        repeat (20) @(negedge clk);
        check("multirow_valid", 32'(pv), 32'd0);
        fil = 4'b0000;
        repeat (10) @(negedge clk);

        // Reset in the middle of a press.
        wait_col(4'b0001);
        @(negedge clk);
        fil = 4'b0100;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_pre", 32'(pv), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(pv), 32'd0);
        check("midrst_numero", numero, 32'd0);
        check("midrst_col", 32'(col), 32'h1);
        check("midrst_prow", 32'(prow), 32'd0);
        @(negedge clk);
        fil = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("restart_hold", 32'(col), 32'h1);
        @(posedge clk);
        #1;
        check("restart_scan", 32'(col), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sistema_de_lectura.md
Name: sistema_de_lectura

Overview:
- Matrix-keypad reader for a 4x4 keypad (rows = fil, columns = col).
- Drives a rotating one-hot column strobe and samples row inputs through a synchronizer.
- Debounces presses, latches one key event and decodes it to a number plus reset/save command flags.
- Sits between the board keypad pins and the consumer logic, which takes each event with a read-acknowledge handshake.

Parameters:
- WIDTH, 4, rows/columns of the matrix. Key decoding is defined only for 4.
- DEBOUNCE_PULSES, 3, consecutive identical nonzero synchronized row samples required to accept a press. The same count of consecutive zero samples is required to accept a release. Must be >= 1.
- SCAN_CYCLES, 8, clock cycles each column stays driven before the strobe advances. Must be >= 4.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- col  output  WIDTH  one-hot column strobe driven to the keypad.
- fil  input  WIDTH  row sense lines, active-high, asynchronous.
- pressed_col_out  output  WIDTH  one-hot column of the latched key.
- pressed_row_out  output  WIDTH  one-hot row of the latched key.
- pressed_valid  output  1  latched event pending; held until acknowledged.
- ack_read  input  1  consumer acknowledge; clears the pending event.
- numero  output  32 (signed integer)  decoded key code of the latched key.
- rst  output  1  command flag: the latched key is '*'. This is not a reset input.
- guardar  output  1  command flag: the latched key is '#'.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - col=0001; pressed_col_out=0, pressed_row_out=0, pressed_valid=0, numero=0, rst=0, guardar=0.
  - Synchronizer, counters and FSM are cleared; state=SCAN.
  - Reset mid-press discards everything. After release of reset the block restarts scanning at column 0.
- Synchronizer: fil passes through 2 flip-flops (fil_s). A 2-deep pipeline of col (col_d) is kept aligned with fil_s, so each row sample is paired with the column that produced it.
- Scan: in SCAN, col is held for SCAN_CYCLES cycles, then rotates left: 0001->0010->0100->1000->0001. Rotation freezes, with its cycle counter held, whenever fil_s != 0 or state != SCAN.
- FSM states SCAN, DEBOUNCE, HELD, RELEASE:
  - SCAN -> DEBOUNCE when fil_s != 0. The debounce counter loads 1 and the sample plus col_d are captured.
  - DEBOUNCE:
    - Each edge where fil_s equals the captured sample increments the counter.
    - Any difference returns the FSM to SCAN, or restarts the count if the new sample is nonzero.
    - When the counter reaches DEBOUNCE_PULSES, the event is latched if the sample is one-hot and pressed_valid=0; the FSM then goes to HELD.
    - If the sample is not one-hot (multiple rows), or an unacknowledged event is pending, nothing is latched and the FSM still goes to HELD.
  - HELD -> RELEASE when fil_s == 0.
  - RELEASE -> SCAN after DEBOUNCE_PULSES consecutive zero samples. Any nonzero sample returns the FSM to HELD. One event per physical press.
- Latency: pressed_valid rises after the (DEBOUNCE_PULSES+1)th rising edge following the first edge at which fil is sampled nonzero (4 edges at the default).
- Latch: one registered update writes pressed_col_out=captured column, pressed_row_out=sample, numero, and pressed_valid=1.
- numero by row r, column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits 0-9; A=10, B=11, C=12, D=13, *=14, #=15.
  - numero holds its last value until the next latch. It is not cleared by ack_read.
- rst = pressed_valid AND numero==14; guardar = pressed_valid AND numero==15. Both are combinational from registered state.
- Handshake:
  - ack_read=1 on an edge clears pressed_valid on that edge. pressed_col_out and pressed_row_out keep their values.
  - ack_read while pressed_valid=0 is ignored.
  - A latch and an ack can never fall on the same edge, because latching requires pressed_valid=0.

Test Plan:
- After reset, fil=0: col rotates 0001,0010,0100,1000 every 8 cycles; pressed_valid=0, numero=0, rst=0, guardar=0.
- Wait for col=0001, assert fil=0100 for 100 cycles, then release.
  - col freezes at 0001; pressed_valid=1 after 4 edges; pcol=0001, prow=0100, numero=7, rst=0, guardar=0.
  - After 50 idle cycles, pulse ack_read -> pressed_valid=0 next edge.
- Wait for col=0001, fil=0001 for 40 cycles -> pcol=0001, prow=0001, numero=1, valid=1; ack clears it.
- col=0001, fil=1000 -> numero=14, rst=1. Then col=0100, fil=1000 -> numero=15, guardar=1. Both flags drop on ack.
- Bounce: fil toggles 0100/0000 every cycle for 10 cycles, then stable 0100 -> exactly one event, latched only after 3 stable samples; no second event until release is debounced.
- Second press while valid=1 and unacknowledged -> outputs unchanged. fil=0110 (two rows) -> no latch.
